// File: rtl/usb_token_tx_seq_if.sv
// Signal bundle linking the token sequencer to the host token source,
// the downstream bit-stuff/NRZI stage and the shared crc5 engine.
interface usb_token_tx_seq_if;
  // A token transfers on a clock edge where tok_valid & tok_ready. A tx bit
  // transfers on an edge where tx_valid & tx_ack. While tx_valid & ~tx_ack,
  // tx_bit/tx_se0 hold. tx_ack with tx_valid low is ignored.
  logic       tok_valid;
  logic       tok_ready;
  logic [3:0] tok_pid;
  logic [6:0] tok_addr;
  logic [3:0] tok_endp;
  logic       tx_valid;
  logic       tx_ack;
  logic       tx_bit;
  logic       tx_se0;
  logic       crc_start;
  logic       crc_s_in;
  logic       crc_send;
  logic       crc_rec;
  logic       crc_bit;
  logic       crc_ready;
  logic       crc_done;

  modport master (
    input  tok_valid, tok_pid, tok_addr, tok_endp,
    input  tx_ack,
    input  crc_bit, crc_ready, crc_done,
    output tok_ready,
    output tx_valid, tx_bit, tx_se0,
    output crc_start, crc_s_in, crc_send, crc_rec
  );

  modport slave (
    output tok_valid, tok_pid, tok_addr, tok_endp,
    output tx_ack,
    output crc_bit, crc_ready, crc_done,
    input  tok_ready,
    input  tx_valid, tx_bit, tx_se0,
    input  crc_start, crc_s_in, crc_send, crc_rec
  );
endinterface

// File: rtl/usb_token_tx_seq.sv
// USB token packet sequencer: serialises SYNC, PID, ADDR, ENDP, CRC5 and EOP
// for one token per request and drives the shared crc5 engine.
module usb_token_tx_seq #(
  parameter logic [7:0]  SYNC_PATTERN = 8'h80,
  parameter int unsigned EOP_SE0_BITS = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  usb_token_tx_seq_if.master bus,
  output logic [2:0]         dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SYNC = 3'd1,
    S_PID  = 3'd2,
    S_DATA = 3'd3,
    S_CRC  = 3'd4,
    S_EOP  = 3'd5
  } state_e;

  // Bit index of the J bit inside the EOP; indices below it are SE0.
  localparam logic [3:0] J_IDX = 4'(EOP_SE0_BITS);

  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  pid_q, pid_d;
  logic [10:0] data_q, data_d;
  logic        crc_start_q, crc_start_d;
  logic        feed_act_q, feed_act_d;
  logic [3:0]  feed_idx_q, feed_idx_d;
  logic        done_seen_q, done_seen_d;
  logic        rec_done_q, rec_done_d;
  logic        j_done_q, j_done_d;

  logic tok_ready_c;
  logic tx_valid_c;
  logic tx_bit_c;
  logic tx_se0_c;
  logic crc_send_c;
  logic crc_rec_c;
  logic bit_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      pid_q       <= '0;
      data_q      <= '0;
      crc_start_q <= 1'b0;
      feed_act_q  <= 1'b0;
      feed_idx_q  <= '0;
      done_seen_q <= 1'b0;
      rec_done_q  <= 1'b0;
      j_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      pid_q       <= pid_d;
      data_q      <= data_d;
      crc_start_q <= crc_start_d;
      feed_act_q  <= feed_act_d;
      feed_idx_q  <= feed_idx_d;
      done_seen_q <= done_seen_d;
      rec_done_q  <= rec_done_d;
      j_done_q    <= j_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    pid_d       = pid_q;
    data_d      = data_q;
    crc_start_d = 1'b0;
    done_seen_d = done_seen_q | bus.crc_done;
    rec_done_d  = rec_done_q;
    j_done_d    = j_done_q;
    tok_ready_c = 1'b0;
    tx_valid_c  = 1'b0;
    tx_bit_c    = 1'b1;
    tx_se0_c    = 1'b0;
    crc_send_c  = 1'b0;
    crc_rec_c   = 1'b0;
    bit_acc     = 1'b0;

    // The feed runs on its own from the cycle after crc_start, ignoring tx_ack.
    feed_act_d = feed_act_q;
    feed_idx_d = feed_idx_q;
    if (crc_start_q) begin
      feed_act_d = 1'b1;
      feed_idx_d = '0;
    end else if (feed_act_q) begin
      if (feed_idx_q == 4'd10) begin
        feed_act_d = 1'b0;
      end else begin
        feed_idx_d = feed_idx_q + 4'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        tok_ready_c = 1'b1;
        done_seen_d = 1'b0;
        rec_done_d  = 1'b0;
        j_done_d    = 1'b0;
        if (bus.tok_valid) begin
          pid_d       = bus.tok_pid;
          data_d      = {bus.tok_endp, bus.tok_addr};
          crc_start_d = 1'b1;
          bit_cnt_d   = '0;
          state_d     = S_SYNC;
        end
      end
      S_SYNC: begin
        tx_valid_c = 1'b1;
        tx_bit_c   = SYNC_PATTERN[bit_cnt_q[2:0]];
        bit_acc    = bus.tx_ack;
        if (bit_acc) begin
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            state_d   = S_PID;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      S_PID: begin
        tx_valid_c = 1'b1;
        // Upper four bit-times carry the complemented check nibble.
        tx_bit_c   = bit_cnt_q[2] ? ~pid_q[bit_cnt_q[1:0]] : pid_q[bit_cnt_q[1:0]];
        bit_acc    = bus.tx_ack;
        if (bit_acc) begin
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            state_d   = S_DATA;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        tx_valid_c = 1'b1;
        tx_bit_c   = data_q[bit_cnt_q];
        bit_acc    = bus.tx_ack;
        if (bit_acc) begin
          if (bit_cnt_q == 4'd10) begin
            bit_cnt_d = '0;
            state_d   = S_CRC;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      S_CRC: begin
        // Bits come straight from the engine; a late crc_ready just stalls.
        tx_valid_c = bus.crc_ready;
        tx_bit_c   = bus.crc_bit;
        bit_acc    = bus.crc_ready & bus.tx_ack;
        crc_send_c = bit_acc;
        if (bit_acc) begin
          if (bit_cnt_q == 4'd4) begin
            bit_cnt_d = '0;
            state_d   = S_EOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      S_EOP: begin
        tx_valid_c = ~j_done_q;
        tx_se0_c   = (bit_cnt_q < J_IDX);
        tx_bit_c   = ~tx_se0_c;
        crc_rec_c  = (bus.crc_done | done_seen_q) & ~rec_done_q;
        if (crc_rec_c) begin
          rec_done_d = 1'b1;
        end
        bit_acc = tx_valid_c & bus.tx_ack;
        if (bit_acc) begin
          if (bit_cnt_q == J_IDX) begin
            j_done_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        // Leave only once both the J bit and the engine release are done.
        if (j_done_d && rec_done_d) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.tok_ready = tok_ready_c;
  assign bus.tx_valid  = tx_valid_c;
  assign bus.tx_bit    = tx_bit_c;
  assign bus.tx_se0    = tx_se0_c;
  assign bus.crc_start = crc_start_q;
  assign bus.crc_s_in  = feed_act_q & data_q[feed_idx_q];
  assign bus.crc_send  = crc_send_c;
  assign bus.crc_rec   = crc_rec_c;
  assign dbg_state_o   = state_q;

endmodule
